// File: rtl/nco_pkg.sv
// Shared constants and types for the carrier NCO and its quarter-wave lookup.
// The optional phase dither (macro CARRIER_NCO_DITHER_EN) uses the LFSR constants here.
package nco_pkg;

    localparam int PHASE_WIDTH_DEF = 32;
    localparam int COUNT_WIDTH_DEF = 16;
    localparam int LUT_IDX_W       = 6;
    localparam int MAG_W           = 4;

    // Quarter-wave magnitudes, round(15*cos((k+0.5)*pi/32)).
    // Element 0 is the rightmost entry of the literal.
    localparam logic [15:0][MAG_W-1:0] QUARTER_TABLE = {
        4'd1,  4'd2,  4'd4,  4'd5,  4'd6,  4'd8,  4'd9,  4'd10,
        4'd11, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15
    };

    // Fibonacci LFSR x^16 + x^14 + x^13 + x^11 + 1 (tap bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One quantised carrier sample: magnitude plus sign (1 = negative).
    typedef struct packed {
        logic [MAG_W-1:0] cos_mag;
        logic [MAG_W-1:0] sin_mag;
        logic             cos_sign;
        logic             sin_sign;
    } iq_sample_t;

endpackage

// File: rtl/carrier_quarter_lut.sv
// Combinational 64-point cos/sin lookup built from a 16-entry quarter table.
// index[5:4] selects the quadrant, index[3:0] the position inside it.
module carrier_quarter_lut
    import nco_pkg::*;
(
    input  logic [LUT_IDX_W-1:0] index,
    output logic [MAG_W-1:0]     cos_value,
    output logic [MAG_W-1:0]     sin_value,
    output logic                 cos_sign,
    output logic                 sin_sign
);

    logic [1:0] q;
    logic [3:0] k;

    // Odd quadrants mirror the table; signs follow the quadrant.
    always_comb begin
        q         = index[5:4];
        k         = index[3:0];
        cos_value = q[0] ? QUARTER_TABLE[~k] : QUARTER_TABLE[k];
        sin_value = q[0] ? QUARTER_TABLE[k]  : QUARTER_TABLE[~k];
        cos_sign  = q[1] ^ q[0];
        sin_sign  = q[1];
    end

endmodule

// File: rtl/carrier_nco.sv
// Carrier NCO for one correlator channel: phase accumulator, carrier-cycle
// counter and registered quantised cos/sin output, one value per valid sample.
// Optional lookup-phase dither enabled by defining CARRIER_NCO_DITHER_EN.
module carrier_nco
    import nco_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   sample_valid_i,
    input  logic [PHASE_WIDTH-1:0] carrier_freq_i,
    input  logic                   phase_load_i,
    input  logic [PHASE_WIDTH-1:0] carrier_phase_i,
    output logic [MAG_W-1:0]       cos_value_o,
    output logic [MAG_W-1:0]       sin_value_o,
    output logic                   cos_sign_o,
    output logic                   sin_sign_o,
    output logic                   nco_valid_o,
    output logic [PHASE_WIDTH-1:0] carrier_phase_o,
    output logic [COUNT_WIDTH-1:0] carrier_count_o
);

    localparam int STAGES = 1;

    logic [PHASE_WIDTH-1:0] acc;
    logic [PHASE_WIDTH-1:0] phase_eff;
    logic [PHASE_WIDTH:0]   sum;
    logic                   carry;
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] cnt_base;
    logic [LUT_IDX_W-1:0]   lut_idx;
    iq_sample_t             lut_out;
    iq_sample_t             out_q;
    logic [STAGES:0]        vld_pipe;

    // Effective phase for this cycle, the advanced phase and the counter base.
    always_comb begin
        phase_eff = phase_load_i ? carrier_phase_i : acc;
        sum       = {1'b0, phase_eff} + {1'b0, carrier_freq_i};
        carry     = sum[PHASE_WIDTH];
        cnt_base  = phase_load_i ? '0 : cnt;
    end

`ifdef CARRIER_NCO_DITHER_EN
    logic [15:0] lfsr;
    logic [15:0] dith_hi;

    // LFSR steps once per sample; a phase load leaves it running.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)              lfsr <= LFSR_SEED;
        else if (sample_valid_i) lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    // Dither only perturbs the lookup index; the top 16 phase bits are
    // enough since the added value is zero below bit PW-16.
    always_comb begin
        dith_hi = phase_eff[PHASE_WIDTH-1 -: 16] + {6'b0, lfsr[9:0]};
        lut_idx = dith_hi[15 -: LUT_IDX_W];
    end
`else
    // Lookup index is the top bits of the effective phase.
    always_comb begin
        lut_idx = phase_eff[PHASE_WIDTH-1 -: LUT_IDX_W];
    end
`endif

    carrier_quarter_lut u_lut (
        .index     (lut_idx),
        .cos_value (lut_out.cos_mag),
        .sin_value (lut_out.sin_mag),
        .cos_sign  (lut_out.cos_sign),
        .sin_sign  (lut_out.sin_sign)
    );

    // Accumulator advances on a sample, otherwise just takes the (loaded) phase.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)              acc <= '0;
        else if (sample_valid_i) acc <= sum[PHASE_WIDTH-1:0];
        else                     acc <= phase_eff;
    end

    // Carrier-cycle counter: a load clears it, a carry on a sample adds one.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)                      cnt <= '0;
        else if (sample_valid_i && carry) cnt <= cnt_base + COUNT_WIDTH'(1);
        else                             cnt <= cnt_base;
    end

    // Output sample register; holds its value across sample gaps.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)              out_q <= '0;
        else if (sample_valid_i) out_q <= lut_out;
    end

    assign vld_pipe[0] = sample_valid_i;

    // Valid shift register aligned with the output register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) vld_pipe[STAGES:1] <= '0;
        else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    assign cos_value_o     = out_q.cos_mag;
    assign sin_value_o     = out_q.sin_mag;
    assign cos_sign_o      = out_q.cos_sign;
    assign sin_sign_o      = out_q.sin_sign;
    assign nco_valid_o     = vld_pipe[STAGES];
    assign carrier_phase_o = acc;
    assign carrier_count_o = cnt;

endmodule

// File: tb/tb_carrier_nco.sv
// Directed bench for carrier_nco (default build, no dither).
module tb_carrier_nco;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        sample_valid_i;
    logic [31:0] carrier_freq_i;
    logic        phase_load_i;
    logic [31:0] carrier_phase_i;
    logic [3:0]  cos_value_o;
    logic [3:0]  sin_value_o;
    logic        cos_sign_o;
    logic        sin_sign_o;
    logic        nco_valid_o;
    logic [31:0] carrier_phase_o;
    logic [15:0] carrier_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    carrier_nco #(.PHASE_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .sample_valid_i  (sample_valid_i),
        .carrier_freq_i  (carrier_freq_i),
        .phase_load_i    (phase_load_i),
        .carrier_phase_i (carrier_phase_i),
        .cos_value_o     (cos_value_o),
        .sin_value_o     (sin_value_o),
        .cos_sign_o      (cos_sign_o),
        .sin_sign_o      (sin_sign_o),
        .nco_valid_o     (nco_valid_o),
        .carrier_phase_o (carrier_phase_o),
        .carrier_count_o (carrier_count_o)
    );

    typedef struct {
        logic        v;
        logic        ld;
        logic [31:0] freq;
        logic [31:0] ph;
        logic        ev;
        logic [3:0]  ec;
        logic        ecs;
        logic [3:0]  es;
        logic        ess;
        logic [31:0] ephase;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [3:0] ec, input logic ecs,
                             input logic [3:0] es, input logic ess, input logic [31:0] eph,
                             input logic [15:0] ecnt);
        check({tag, ".valid"}, 64'(nco_valid_o), 64'(ev));
        check({tag, ".cos"},   64'(cos_value_o), 64'(ec));
        check({tag, ".cos_s"}, 64'(cos_sign_o),  64'(ecs));
        check({tag, ".sin"},   64'(sin_value_o), 64'(es));
        check({tag, ".sin_s"}, 64'(sin_sign_o),  64'(ess));
        check({tag, ".phase"}, 64'(carrier_phase_o), 64'(eph));
        check({tag, ".count"}, 64'(carrier_count_o), 64'(ecnt));
    endtask

    // Drive at the negedge, let one posedge pass, return at the next negedge.
    task automatic step(input logic v, input logic ld, input logic [31:0] freq, input logic [31:0] ph);
        sample_valid_i  = v;
        phase_load_i    = ld;
        carrier_freq_i  = freq;
        carrier_phase_i = ph;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        //          v  ld freq          ph            ev cos cs sin ss phase         cnt
        vecs[0]  = '{1, 0, 32'h04000000, 32'h0,        1, 15, 0, 1,  0, 32'h04000000, 16'h0};
        vecs[1]  = '{1, 1, 32'h40000000, 32'h0,        1, 15, 0, 1,  0, 32'h40000000, 16'h0};
        vecs[2]  = '{1, 0, 32'h40000000, 32'h0,        1, 1,  1, 15, 0, 32'h80000000, 16'h0};
        vecs[3]  = '{1, 0, 32'h40000000, 32'h0,        1, 15, 1, 1,  1, 32'hC0000000, 16'h0};
        vecs[4]  = '{1, 0, 32'h40000000, 32'h0,        1, 1,  0, 15, 1, 32'h00000000, 16'h1};
        vecs[5]  = '{1, 1, 32'h80000000, 32'h80000000, 1, 15, 1, 1,  1, 32'h00000000, 16'h1};
        vecs[6]  = '{0, 0, 32'h12345678, 32'h0,        0, 15, 1, 1,  1, 32'h00000000, 16'h1};
        vecs[7]  = '{0, 0, 32'h40000000, 32'h0,        0, 15, 1, 1,  1, 32'h00000000, 16'h1};
        vecs[8]  = '{0, 0, 32'h40000000, 32'h0,        0, 15, 1, 1,  1, 32'h00000000, 16'h1};
        vecs[9]  = '{0, 1, 32'h40000000, 32'h12345678, 0, 15, 1, 1,  1, 32'h12345678, 16'h0};
        vecs[10] = '{1, 0, 32'h00000000, 32'h0,        1, 14, 0, 6,  0, 32'h12345678, 16'h0};
        vecs[11] = '{1, 1, 32'h10000000, 32'h6C000000, 1, 14, 1, 6,  0, 32'h7C000000, 16'h0};
        vecs[12] = '{1, 0, 32'h10000000, 32'h0,        1, 15, 1, 1,  0, 32'h8C000000, 16'h0};
        vecs[13] = '{0, 0, 32'h10000000, 32'h0,        0, 15, 1, 1,  0, 32'h8C000000, 16'h0};

        rst_b           = 1'b0;
        sample_valid_i  = 1'b0;
        phase_load_i    = 1'b0;
        carrier_freq_i  = '0;
        carrier_phase_i = '0;
        repeat (2) @(negedge clk);
        check_all("reset", 0, 0, 0, 0, 0, 32'h0, 16'h0);
        rst_b = 1'b1;

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].v, vecs[i].ld, vecs[i].freq, vecs[i].ph);
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ec, vecs[i].ecs,
                      vecs[i].es, vecs[i].ess, vecs[i].ephase, vecs[i].ecnt);
        end

        // Mid-stream reset: outputs clear without a clock edge.
        step(1, 0, 32'h40000000, 32'h0);
        #2 rst_b = 1'b0;
        #1 check_all("async_rst", 0, 0, 0, 0, 0, 32'h0, 16'h0);
        @(negedge clk);
        rst_b = 1'b1;
        step(1, 0, 32'h04000000, 32'h0);
        check_all("post_rst", 1, 15, 0, 1, 0, 32'h04000000, 16'h0);

        // Counter wrap: every sample with freq=all-ones carries while acc != 0.
        step(1, 1, 32'hFFFFFFFF, 32'h0);
        check("wrap.start_cnt", 64'(carrier_count_o), 64'h0);
        for (int i = 0; i < 65535; i++) step(1, 0, 32'hFFFFFFFF, 32'h0);
        check("wrap.cnt_ffff", 64'(carrier_count_o), 64'hFFFF);
        check("wrap.phase_a",  64'(carrier_phase_o), 64'hFFFF0000);
        step(1, 0, 32'hFFFFFFFF, 32'h0);
        check("wrap.cnt_0",    64'(carrier_count_o), 64'h0);
        check("wrap.phase_b",  64'(carrier_phase_o), 64'hFFFEFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
